// File: rtl/cpu_confreg_if.sv
// Data-port bus between the mips core and the confreg block.
// The core drives the request; the block returns registered read data.
interface cpu_confreg_if;
  logic        en;
  logic [3:0]  memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output en, memwrite, addr, writedata, input readdata);
  modport slave  (input en, memwrite, addr, writedata, output readdata);
endinterface

// File: rtl/cpu_confreg.sv
// Configuration/peripheral registers on the CPU data port: LEDs, seven-segment
// value, scratch, synchronised switches and a free-running timer with compare IRQ.
module cpu_confreg #(
  parameter logic [15:0] BASE_HI = 16'hBFAF,
  parameter int          SW_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  cpu_confreg_if.slave    bus,
  input  logic [SW_W-1:0] switch,
  output logic [15:0]     led,
  output logic [1:0]      led_rg0,
  output logic [1:0]      led_rg1,
  output logic [31:0]     num_data,
  output logic            timer_int
);

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_RG0     = 16'hF004;
  localparam logic [15:0] OFF_RG1     = 16'hF008;
  localparam logic [15:0] OFF_NUM     = 16'hF010;
  localparam logic [15:0] OFF_SWITCH  = 16'hF020;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;
  localparam logic [15:0] OFF_SCRATCH = 16'hE008;

  logic [31:0]     timer;
  logic [31:0]     compare;
  logic [31:0]     scratch;
  logic            pending;
  logic [31:0]     readdata_q;
  logic [SW_W-1:0] sw_sync1;
  logic [SW_W-1:0] sw_sync2;

  logic [15:0] offset;
  logic        hit;
  logic        wr;
  logic        rd_req;
  logic        wr_led;
  logic        wr_rg0;
  logic        wr_rg1;
  logic        wr_num;
  logic        wr_timer;
  logic        wr_compare;
  logic        wr_scratch;
  logic [31:0] rdata;
  logic [31:0] sw_ext;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  // The low two address bits are don't-care: registers are word aligned.
  assign offset = bus.addr[15:0] & 16'hFFFC;
  assign hit    = bus.en && (bus.addr[31:16] == BASE_HI);
  assign wr     = hit && (bus.memwrite != 4'h0);
  assign rd_req = bus.en && (bus.memwrite == 4'h0);

  assign wr_led     = wr && (offset == OFF_LED);
  assign wr_rg0     = wr && (offset == OFF_RG0);
  assign wr_rg1     = wr && (offset == OFF_RG1);
  assign wr_num     = wr && (offset == OFF_NUM);
  assign wr_timer   = wr && (offset == OFF_TIMER);
  assign wr_compare = wr && (offset == OFF_COMPARE);
  assign wr_scratch = wr && (offset == OFF_SCRATCH);

  assign sw_ext = 32'(sw_sync2);

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_LED:     rdata = {16'h0, led};
      OFF_RG0:     rdata = {30'h0, led_rg0};
      OFF_RG1:     rdata = {30'h0, led_rg1};
      OFF_NUM:     rdata = num_data;
      OFF_SWITCH:  rdata = sw_ext;
      OFF_TIMER:   rdata = timer;
      OFF_COMPARE: rdata = compare;
      OFF_SCRATCH: rdata = scratch;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led        <= 16'hFFFF;
      led_rg0    <= 2'b00;
      led_rg1    <= 2'b00;
      num_data   <= '0;
      timer      <= '0;
      compare    <= '0;
      scratch    <= '0;
      pending    <= 1'b0;
      readdata_q <= '0;
      sw_sync1   <= '0;
      sw_sync2   <= '0;
    end else begin
      sw_sync1 <= switch;
      sw_sync2 <= sw_sync1;

      // Idle cycles and writes leave the last read result in place.
      if (rd_req) readdata_q <= hit ? rdata : 32'h0;

      if (wr_led) begin
        if (bus.memwrite[0]) led[7:0]  <= bus.writedata[7:0];
        if (bus.memwrite[1]) led[15:8] <= bus.writedata[15:8];
      end
      if (wr_rg0 && bus.memwrite[0]) led_rg0 <= bus.writedata[1:0];
      if (wr_rg1 && bus.memwrite[0]) led_rg1 <= bus.writedata[1:0];
      if (wr_num)     num_data <= merge_lanes(num_data, bus.writedata, bus.memwrite);
      if (wr_compare) compare  <= merge_lanes(compare, bus.writedata, bus.memwrite);
      if (wr_scratch) scratch  <= merge_lanes(scratch, bus.writedata, bus.memwrite);

      // A timer write freezes the unwritten lanes at their pre-increment value.
      if (wr_timer) timer <= merge_lanes(timer, bus.writedata, bus.memwrite);
      else          timer <= timer + 32'd1;

      // Clearing by a compare write takes priority over a match on the same edge.
      if (wr_compare)                                pending <= 1'b0;
      else if ((compare != 32'h0) && (timer == compare)) pending <= 1'b1;
    end
  end

  assign bus.readdata = readdata_q;
  assign timer_int    = pending;

endmodule

// File: tb/tb_cpu_confreg.sv
// Self-checking bench for cpu_confreg: directed scenarios plus randomized traffic
// checked every cycle against a register-map reference model.
module tb_cpu_confreg;
  localparam int SW_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [SW_W-1:0] switch;
  logic [15:0]     led;
  logic [1:0]      led_rg0;
  logic [1:0]      led_rg1;
  logic [31:0]     num_data;
  logic            timer_int;

  cpu_confreg_if bus();

  cpu_confreg #(.BASE_HI(16'hBFAF), .SW_W(SW_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .switch(switch),
    .led(led),
    .led_rg0(led_rg0),
    .led_rg1(led_rg1),
    .num_data(num_data),
    .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: register map as an offset-keyed table with width masks.
  logic [31:0]     mreg  [int];
  logic [31:0]     mmask [int];
  logic [SW_W-1:0] swHist [2];
  logic            mPend;
  logic [31:0]     mRd;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input int off);
    if (off == 32'hF020) return 32'(swHist[1]);
    if (mreg.exists(off)) return mreg[off];
    return 32'h0;
  endfunction

  task automatic modelStep(input logic r, input logic e, input logic [3:0] we,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [SW_W-1:0] sw);
    int          off;
    logic        hit;
    logic [31:0] oldT;
    logic [31:0] oldC;
    logic [31:0] nv;
    if (!r) begin
      foreach (mmask[k]) mreg[k] = (k == 32'hF000) ? 32'hFFFF : 32'h0;
      mPend = 1'b0;
      mRd = 32'h0;
      swHist[0] = '0;
      swHist[1] = '0;
      return;
    end
    hit  = e && (a[31:16] == 16'hBFAF);
    off  = int'({16'h0, a[15:2], 2'b00});
    oldT = mreg[32'hE000];
    oldC = mreg[32'hE004];
    if (e && we == 4'h0) mRd = hit ? modelRead(off) : 32'h0;
    mreg[32'hE000] = oldT + 32'd1;
    if (hit && we != 4'h0 && mmask.exists(off)) begin
      nv = (off == 32'hE000) ? oldT : mreg[off];
      for (int i = 0; i < 4; i++) if (we[i]) nv[8*i +: 8] = d[8*i +: 8];
      mreg[off] = nv & mmask[off];
    end
    if (hit && we != 4'h0 && off == 32'hE004) mPend = 1'b0;
    else if (oldC != 32'h0 && oldT == oldC)   mPend = 1'b1;
    swHist[1] = swHist[0];
    swHist[0] = sw;
  endtask

  // One clock cycle: drive, clock, advance the model, compare all outputs.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] we,
                               input logic [31:0] a, input logic [31:0] d);
    rst = r;
    bus.en = e;
    bus.memwrite = we;
    bus.addr = a;
    bus.writedata = d;
    @(posedge clk);
    modelStep(r, e, we, a, d, switch);
    #1;
    checkOutput("led", 32'(led), mreg[32'hF000]);
    checkOutput("led_rg0", 32'(led_rg0), mreg[32'hF004]);
    checkOutput("led_rg1", 32'(led_rg1), mreg[32'hF008]);
    checkOutput("num_data", num_data, mreg[32'hF010]);
    checkOutput("timer_int", 32'(timer_int), 32'(mPend));
    checkOutput("readdata", bus.readdata, mRd);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wrReg(input logic [15:0] off, input logic [3:0] we, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, we, {16'hBFAF, off}, d);
  endtask

  task automatic rdReg(input logic [15:0] off);
    applyStimulus(1'b1, 1'b1, 4'h0, {16'hBFAF, off}, 32'h0);
  endtask

  int offs [10] = '{32'hF000, 32'hF004, 32'hF008, 32'hF010, 32'hF020,
                    32'hE000, 32'hE004, 32'hE008, 32'hF0FC, 32'hF00C};

  initial begin
    logic        r;
    logic        e;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
    int          off;

    mmask[32'hF000] = 32'h0000FFFF;
    mmask[32'hF004] = 32'h00000003;
    mmask[32'hF008] = 32'h00000003;
    mmask[32'hF010] = 32'hFFFFFFFF;
    mmask[32'hE000] = 32'hFFFFFFFF;
    mmask[32'hE004] = 32'hFFFFFFFF;
    mmask[32'hE008] = 32'hFFFFFFFF;
    switch = '0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("rst_led", 32'(led), 32'h0000FFFF);
    checkOutput("rst_num", num_data, 32'h0);
    checkOutput("rst_int", 32'(timer_int), 32'h0);
    checkOutput("rst_rd", bus.readdata, 32'h0);
    idle();
    idle();
    rdReg(16'hE000);
    checkOutput("timer_after_rst", bus.readdata, 32'd2);

    $display("[TB] byte lanes");
    wrReg(16'hF010, 4'hF, 32'h12345678);
    wrReg(16'hF010, 4'b0010, 32'h0000AB00);
    checkOutput("num_lane1", num_data, 32'h1234AB78);
    rdReg(16'hF010);
    checkOutput("num_read", bus.readdata, 32'h1234AB78);

    $display("[TB] timer load and wrap");
    wrReg(16'hE000, 4'hF, 32'hFFFFFFFE);
    idle();
    idle();
    rdReg(16'hE000);
    checkOutput("timer_wrap", bus.readdata, 32'h0);
    wrReg(16'hE000, 4'hF, 32'h123456FF);
    wrReg(16'hE000, 4'b0001, 32'h00000010);
    rdReg(16'hE000);
    checkOutput("timer_partial", bus.readdata, 32'h12345610);

    $display("[TB] interrupt");
    wrReg(16'hE004, 4'hF, 32'd10);
    wrReg(16'hE000, 4'hF, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      idle();
      checkOutput("int_rise", 32'(timer_int), (k >= 11) ? 32'h1 : 32'h0);
    end
    wrReg(16'hE004, 4'hF, 32'd0);
    for (int k = 0; k < 20; k++) begin
      idle();
      checkOutput("int_disabled", 32'(timer_int), 32'h0);
    end
    wrReg(16'hE004, 4'hF, 32'd10);
    wrReg(16'hE000, 4'hF, 32'd0);
    for (int k = 0; k < 10; k++) idle();
    wrReg(16'hE004, 4'hF, 32'd10);
    checkOutput("int_clear_wins", 32'(timer_int), 32'h0);
    idle();
    checkOutput("int_clear_hold", 32'(timer_int), 32'h0);

    $display("[TB] decode");
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h8000F000, 32'h0);
    checkOutput("miss_base_led", 32'(led), 32'h0000FFFF);
    wrReg(16'hF0FC, 4'hF, 32'hDEADBEEF);
    rdReg(16'hF0FC);
    checkOutput("hole_read", bus.readdata, 32'h0);
    rdReg(16'hF010);
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h8000F010, 32'h0);
    checkOutput("miss_read", bus.readdata, 32'h0);
    switch = 8'hA5;
    idle();
    idle();
    rdReg(16'hF020);
    checkOutput("switch_sync", bus.readdata, 32'h000000A5);

    $display("[TB] reset during write");
    wrReg(16'hF000, 4'b0011, 32'h00001234);
    checkOutput("led_write", 32'(led), 32'h00001234);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'hBFAFF000, 32'h0);
    checkOutput("led_rst_wins", 32'(led), 32'h0000FFFF);
    idle();

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) switch = SW_W'($urandom);
      r   = ($urandom_range(0, 99) != 0);
      e   = ($urandom_range(0, 3) != 0);
      off = offs[$urandom_range(0, 9)];
      a   = {16'hBFAF, off[15:0]};
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[31:16] = 16'($urandom);
      we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d   = $urandom;
      if (off == 32'hE004 && $urandom_range(0, 1) == 1) begin
        we = 4'hF;
        d  = mreg[32'hE000] + 32'($urandom_range(1, 20));
      end
      applyStimulus(r, e, we, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
